// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I datapath (fetch/decode/execute/memory/writeback).
// Define JAL_EN to add the JAL state; without it opcode 1101111 is reported as illegal.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             memReady,
  output logic             memReq,
  output logic             memWrite,
  output logic             adrSrc,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             regWrite,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       resultSrc,
  output logic [1:0]       aluOp,
  output logic             illegalOp,
  output logic [CNT_W-1:0] instrCount,
  output logic [3:0]       fsm_state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
`ifdef JAL_EN
  localparam logic [3:0] JAL      = 4'd10;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef JAL_EN
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

  logic [3:0] state;
  logic [3:0] next_state;
  logic       retire;

  // Unmasked strobes; reset gates them below so nothing fires mid-reset.
  logic mem_req_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic pc_update;
  logic branch;
  logic reg_write_raw;
  logic illegal_raw;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    illegal_raw = 1'b0;
    case (state)
      FETCH: begin
        if (memReady) next_state = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECR;
          OP_ITYPE:          next_state = EXECI;
          OP_BRANCH:         next_state = BEQ;
`ifdef JAL_EN
          OP_JAL:            next_state = JAL;
`endif
          default: begin
            next_state  = FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        next_state = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        if (memReady) next_state = MEMWB;
      end
      MEMWB:    next_state = FETCH;
      MEMWRITE: begin
        if (memReady) next_state = FETCH;
      end
      EXECR:    next_state = ALUWB;
      EXECI:    next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BEQ:      next_state = FETCH;
`ifdef JAL_EN
      JAL:      next_state = ALUWB;
`endif
      default:  next_state = FETCH;
    endcase
  end

  // Moore decode of the datapath controls; only FETCH looks at memReady.
  always_comb begin
    mem_req_raw   = 1'b0;
    mem_write_raw = 1'b0;
    adrSrc        = 1'b0;
    ir_write_raw  = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    reg_write_raw = 1'b0;
    aluSrcA       = 2'b00;
    aluSrcB       = 2'b00;
    resultSrc     = 2'b00;
    aluOp         = 2'b00;
    case (state)
      FETCH: begin
        mem_req_raw  = 1'b1;
        aluSrcB      = 2'b10;
        resultSrc    = 2'b10;
        ir_write_raw = memReady;
        pc_update    = memReady;
      end
      DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
      end
      MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      MEMREAD: begin
        mem_req_raw = 1'b1;
        adrSrc      = 1'b1;
      end
      MEMWB: begin
        resultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        mem_req_raw   = 1'b1;
        mem_write_raw = 1'b1;
        adrSrc        = 1'b1;
      end
      EXECR: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
      end
      EXECI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = 2'b10;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
      end
      BEQ: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b01;
        branch  = 1'b1;
      end
`ifdef JAL_EN
      // Jump target already sits in aluOut; ALU computes the link oldPC+4.
      JAL: begin
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        pc_update = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign memReq    = mem_req_raw & ~reset;
  assign memWrite  = mem_write_raw & ~reset;
  assign irWrite   = ir_write_raw & ~reset;
  assign pcWrite   = (pc_update | (branch & zero)) & ~reset;
  assign regWrite  = reg_write_raw & ~reset;
  assign illegalOp = illegal_raw & ~reset;

  assign retire = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                  ((state == MEMWRITE) && memReady);

  always_ff @(posedge clk) begin
    if (reset) begin
      instrCount <= '0;
    end else if (retire) begin
      instrCount <= instrCount + CNT_W'(1);
    end
  end

endmodule
